// File: rtl/can_pkg.sv
// ============================================================================
// can_pkg : bus levels and bit-tick conventions shared by the CAN tx/rx stages
// Revision: 1.0
// ============================================================================
`default_nettype none

package can_pkg;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  localparam int STUFF_LEN_DEFAULT = 5;
  localparam int CNT_W_DEFAULT     = 3;

  // Both ticks are single-cycle, active-high pulses from the bit timing logic.
  typedef struct packed {
    logic bit_start;
    logic sample;
  } bit_ticks_t;

endpackage

`default_nettype wire

// File: rtl/stuff_run_counter.sv
// ============================================================================
// stuff_run_counter : run-length tracker and stuff-insertion decision
// Revision: 1.0
// ============================================================================
`default_nettype none

module stuff_run_counter
  import can_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  input  logic window,
  input  logic bit_in,
  output logic insert,
  output logic stuff_value
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             w_insert;

  // Leaving the window discards a pending stuff bit.
  assign w_insert    = window && (r_cnt == CNT_W'(STUFF_LEN));
  assign insert      = w_insert;
  assign stuff_value = ~r_last;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      r_cnt  <= '0;
      r_last <= RECESSIVE;
    end else if (advance) begin
      if (w_insert) begin
        // The stuff bit itself starts the next run.
        r_cnt  <= CNT_W'(1);
        r_last <= ~r_last;
      end else if (window) begin
        r_cnt  <= ((bit_in == r_last) && (r_cnt != '0)) ? r_cnt + CNT_W'(1) : CNT_W'(1);
        r_last <= bit_in;
      end else begin
        r_cnt  <= '0;
        r_last <= RECESSIVE;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_stuff_unit.sv
// ============================================================================
// tx_stuff_unit : CAN transmit bit stuffing, shift control and bit monitoring
// Revision: 1.0
// ============================================================================
`default_nettype none

module tx_stuff_unit
  import can_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic tx_en,
  input  logic bittick,
  input  logic smpltick,
  input  logic stuff_en,
  input  logic arb_field,
  input  logic data_in,
  input  logic rx_bit,
  output logic tx_bit,
  output logic shift_req,
  output logic stuff_active,
  output logic bit_error,
  output logic arb_lost
);

  bit_ticks_t w_ticks;
  logic       w_insert;
  logic       w_stuff_value;
  logic       w_mismatch;
  logic       w_arb_loss;

  logic r_tx_bit;
  logic r_shift_req;
  logic r_stuff_active;
  logic r_bit_error;
  logic r_arb_lost;

  assign w_ticks = '{bit_start: bittick, sample: smpltick};

  stuff_run_counter #(
    .STUFF_LEN (STUFF_LEN),
    .CNT_W     (CNT_W)
  ) u_run_counter (
    .clock       (clock),
    .reset       (reset),
    .clear       (~tx_en),
    .advance     (w_ticks.bit_start & tx_en),
    .window      (stuff_en),
    .bit_in      (data_in),
    .insert      (w_insert),
    .stuff_value (w_stuff_value)
  );

  // Compared against the registered bit, i.e. the value before any same-cycle bittick update.
  assign w_mismatch = (rx_bit != r_tx_bit);
  assign w_arb_loss = (r_tx_bit == RECESSIVE) && (rx_bit == DOMINANT) &&
                      arb_field && !r_stuff_active;

  always_ff @(posedge clock) begin
    if (!reset || !tx_en) begin
      r_tx_bit       <= RECESSIVE;
      r_shift_req    <= 1'b0;
      r_stuff_active <= 1'b0;
      r_bit_error    <= 1'b0;
      r_arb_lost     <= 1'b0;
    end else begin
      r_shift_req <= 1'b0;
      r_bit_error <= 1'b0;
      r_arb_lost  <= 1'b0;
      if (w_ticks.bit_start) begin
        if (w_insert) begin
          // Data bit is held: no shift request during a stuff bit time.
          r_tx_bit       <= w_stuff_value;
          r_stuff_active <= 1'b1;
        end else begin
          r_tx_bit       <= data_in;
          r_stuff_active <= 1'b0;
          r_shift_req    <= 1'b1;
        end
      end
      if (w_ticks.sample) begin
        r_bit_error <= w_mismatch && !w_arb_loss;
        r_arb_lost  <= w_mismatch && w_arb_loss;
      end
    end
  end

  assign tx_bit       = r_tx_bit;
  assign shift_req    = r_shift_req;
  assign stuff_active = r_stuff_active;
  assign bit_error    = r_bit_error;
  assign arb_lost     = r_arb_lost;

endmodule

`default_nettype wire

// File: tb/tb_tx_stuff_unit.sv
// ============================================================================
// tb_tx_stuff_unit : directed scoreboard bench for tx_stuff_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tx_stuff_unit;

  logic clock = 1'b0;
  logic reset, tx_en, bittick, smpltick, stuff_en, arb_field, data_in, rx_bit;
  logic tx_bit, shift_req, stuff_active, bit_error, arb_lost;

  int n_vec  = 0;
  int n_fail = 0;
  int sr_count = 0;

  typedef struct {
    logic tx;
    logic sa;
    logic sr;
  } exp_t;

  exp_t sb_q[$];

  always #5 clock = ~clock;

  always @(negedge clock) if (shift_req === 1'b1) sr_count++;

  tx_stuff_unit dut (
    .clock        (clock),
    .reset        (reset),
    .tx_en        (tx_en),
    .bittick      (bittick),
    .smpltick     (smpltick),
    .stuff_en     (stuff_en),
    .arb_field    (arb_field),
    .data_in      (data_in),
    .rx_bit       (rx_bit),
    .tx_bit       (tx_bit),
    .shift_req    (shift_req),
    .stuff_active (stuff_active),
    .bit_error    (bit_error),
    .arb_lost     (arb_lost)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // One nominal bit time: bittick cycle plus three idle cycles.
  task automatic bit_time(input logic d, input logic se, input logic e_tx,
                          input logic e_sa, input logic e_sr);
    exp_t e;
    data_in  = d;
    stuff_en = se;
    bittick  = 1'b1;
    sb_q.push_back('{tx: e_tx, sa: e_sa, sr: e_sr});
    cycle();
    bittick = 1'b0;
    e = sb_q.pop_front();
    check("tx_bit", tx_bit, e.tx);
    check("stuff_active", stuff_active, e.sa);
    check("shift_req", shift_req, e.sr);
    cycle();
    check("shift_req_single", shift_req, 1'b0);
    cycle();
    cycle();
  endtask

  task automatic monitor(input logic rx, input logic arb, input logic e_be, input logic e_al);
    rx_bit    = rx;
    arb_field = arb;
    smpltick  = 1'b1;
    cycle();
    smpltick = 1'b0;
    check("bit_error", bit_error, e_be);
    check("arb_lost", arb_lost, e_al);
    cycle();
    check("bit_error_single", bit_error, 1'b0);
    check("arb_lost_single", arb_lost, 1'b0);
    rx_bit    = 1'b1;
    arb_field = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; tx_en = 1'b0; bittick = 1'b0; smpltick = 1'b0;
    stuff_en = 1'b0; arb_field = 1'b0; data_in = 1'b0; rx_bit = 1'b1;
    cycle(); cycle();
    check("rst_tx_bit", tx_bit, 1'b1);
    check("rst_shift_req", shift_req, 1'b0);
    check("rst_stuff_active", stuff_active, 1'b0);
    check("rst_bit_error", bit_error, 1'b0);
    check("rst_arb_lost", arb_lost, 1'b0);
    reset = 1'b1; tx_en = 1'b1;
    cycle();

    // Five zeros, stuff 1, then 0,1: 8 bit times, 7 shift requests.
    sr_count = 0;
    repeat (5) bit_time(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bit_time(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    bit_time(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bit_time(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    n_vec++;
    assert (sr_count == 7) else begin
      n_fail++;
      $error("FAIL shift_count observed=%0d expected=7", sr_count);
    end

    // Stuff bit counts toward the next run.
    bit_time(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) bit_time(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    bit_time(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) bit_time(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bit_time(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Window closes exactly when a stuff bit is pending.
    bit_time(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) bit_time(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    bit_time(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    bit_time(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Arbitration monitoring.
    bit_time(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    monitor(1'b0, 1'b1, 1'b0, 1'b1);
    monitor(1'b0, 1'b0, 1'b1, 1'b0);
    monitor(1'b1, 1'b1, 1'b0, 1'b0);
    bit_time(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    monitor(1'b1, 1'b1, 1'b1, 1'b0);

    // Recessive stuff bit overwritten during arbitration.
    bit_time(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) bit_time(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bit_time(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    monitor(1'b0, 1'b1, 1'b1, 1'b0);

    // bittick and smpltick together: compare against the old bit (1).
    data_in = 1'b0; stuff_en = 1'b0; rx_bit = 1'b1; arb_field = 1'b0;
    bittick = 1'b1; smpltick = 1'b1;
    cycle();
    bittick = 1'b0; smpltick = 1'b0;
    check("same_tick_tx_bit", tx_bit, 1'b0);
    check("same_tick_bit_error", bit_error, 1'b0);
    check("same_tick_shift_req", shift_req, 1'b1);
    cycle(); cycle();

    // Transmitter disabled: ticks ignored, bus recessive.
    tx_en = 1'b0;
    bittick = 1'b1; data_in = 1'b0;
    cycle();
    bittick = 1'b0;
    check("txoff_tx_bit", tx_bit, 1'b1);
    check("txoff_shift_req", shift_req, 1'b0);
    rx_bit = 1'b0; smpltick = 1'b1;
    cycle();
    smpltick = 1'b0; rx_bit = 1'b1;
    check("txoff_bit_error", bit_error, 1'b0);
    cycle();
    tx_en = 1'b1;
    cycle();

    // Reset mid-frame with four zeros counted.
    repeat (4) bit_time(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    cycle();
    check("midrst_tx_bit", tx_bit, 1'b1);
    check("midrst_shift_req", shift_req, 1'b0);
    check("midrst_stuff_active", stuff_active, 1'b0);
    check("midrst_bit_error", bit_error, 1'b0);
    check("midrst_arb_lost", arb_lost, 1'b0);
    reset = 1'b1;
    cycle();
    repeat (5) bit_time(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bit_time(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
